// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared helpers for the banked scratch memory: ceiling log2,
//                bank-select width and slice extraction from flattened
//                per-port vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Widest flattened port vector and widest single slice the helpers handle
    localparam int VEC_MAX_W   = 1024;
    localparam int SLICE_MAX_W = 64;

    typedef logic [VEC_MAX_W-1:0]   vec_t;
    typedef logic [SLICE_MAX_W-1:0] slice_t;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Number of low address bits that pick the bank
    function automatic int bsel_width(input int num_banks);
        return clog2(num_banks);
    endfunction

    // Slice idx of width w from a flattened vector, zero-extended
    function automatic slice_t slice_get(input vec_t vec, input int idx, input int w);
        slice_t mask;
        mask = (slice_t'(1) << w) - slice_t'(1);
        return slice_t'(vec >> (idx * w)) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bank_slice.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bank_slice
//  Description : One memory bank: word storage, per-word valid bits and a
//                round-robin arbiter choosing one requesting port per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bank_slice
    import mem_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int WORD_W    = 6,
    parameter int NUM_PORTS = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic [NUM_PORTS-1:0]                 req,
    input  logic [NUM_PORTS-1:0]                 wr,
    input  logic [NUM_PORTS-1:0][WORD_W-1:0]     word_idx,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]     wdata,
    output logic [NUM_PORTS-1:0]                 grant,
    output logic                                 rd_vbit,
    output logic [DATA_W-1:0]                    rd_data
);

    localparam int DEPTH = 1 << WORD_W;
    localparam int PTR_W = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DEPTH-1:0]  vbit_q, vbit_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              win_valid;
    logic              win_wr;
    logic [WORD_W-1:0] win_idx;
    logic [DATA_W-1:0] win_data;
    int                cand;

    // Round-robin pick: first requester at or after ptr (cyclic); ptr moves past the winner
    always_comb begin
        grant     = '0;
        win_valid = 1'b0;
        win_wr    = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        ptr_d     = ptr_q;
        cand      = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = (int'(ptr_q) + k) % NUM_PORTS;
            if (!win_valid && req[cand]) begin
                win_valid   = 1'b1;
                grant[cand] = 1'b1;
                win_wr      = wr[cand];
                win_idx     = word_idx[cand];
                win_data    = wdata[cand];
                ptr_d       = PTR_W'((cand + 1) % NUM_PORTS);
            end
        end
    end

    // Clear drops every valid bit, but a write granted in the same cycle still sets its own
    always_comb begin
        vbit_d = clear ? '0 : vbit_q;
        if (win_valid && win_wr) begin
            vbit_d[win_idx] = 1'b1;
        end
    end

    // Read path sees state before this edge's update; unwritten words read as zero
    always_comb begin
        rd_vbit = win_valid && vbit_q[win_idx];
        rd_data = rd_vbit ? mem_q[win_idx] : '0;
    end

    // Arbiter pointer and valid bits are reset; storage is not
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q  <= '0;
            vbit_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            vbit_q <= vbit_d;
        end
    end

    // Word storage, write blocked while reset is held
    always_ff @(posedge clk) begin
        if (reset && win_valid && win_wr) begin
            mem_q[win_idx] <= win_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bank_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bank_array
//  Description : Address-interleaved multi-bank scratch memory shared by
//                several requesters; routes ports to banks and registers
//                read responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bank_array
    import mem_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int NUM_BANKS = 4,
    parameter int NUM_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   port_data_in,
    input  logic [NUM_PORTS-1:0]          port_read_enable,
    input  logic [NUM_PORTS-1:0]          port_write_enable,
    output logic [NUM_PORTS-1:0]          port_ready,
    output logic [NUM_PORTS-1:0]          port_resp,
    output logic [NUM_PORTS-1:0]          port_valid_out,
    output logic [NUM_PORTS*DATA_W-1:0]   port_data_out
);

    localparam int BSEL_W = bsel_width(NUM_BANKS);
    localparam int WORD_W = ADDR_W - BSEL_W;

    logic [NUM_PORTS-1:0][BSEL_W-1:0]  bank_sel;
    logic [NUM_PORTS-1:0][WORD_W-1:0]  word_idx;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  wdata;
    logic [NUM_PORTS-1:0]              port_req;

    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] bank_grant;
    logic [NUM_BANKS-1:0]                bank_rd_vbit;
    logic [NUM_BANKS-1:0][DATA_W-1:0]    bank_rd_data;

    logic [NUM_PORTS-1:0]              resp_q, resp_d;
    logic [NUM_PORTS-1:0]              valid_q, valid_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  data_q, data_d;

    // Split each port's address into bank select (low bits) and word index
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            bank_sel[p] = BSEL_W'(slice_get(vec_t'(port_addr), p, ADDR_W));
            word_idx[p] = WORD_W'(slice_get(vec_t'(port_addr), p, ADDR_W) >> BSEL_W);
            wdata[p]    = DATA_W'(slice_get(vec_t'(port_data_in), p, DATA_W));
            port_req[p] = port_read_enable[p] || port_write_enable[p];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_PORTS-1:0] bank_req;

        // A port requests this bank only when its address lands here
        always_comb begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                bank_req[p] = port_req[p] && (bank_sel[p] == BSEL_W'(b));
            end
        end

        mem_bank_slice #(
            .DATA_W    (DATA_W),
            .WORD_W    (WORD_W),
            .NUM_PORTS (NUM_PORTS)
        ) u_slice (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .req      (bank_req),
            .wr       (port_write_enable),
            .word_idx (word_idx),
            .wdata    (wdata),
            .grant    (bank_grant[b]),
            .rd_vbit  (bank_rd_vbit[b]),
            .rd_data  (bank_rd_data[b])
        );
    end

    // Ready and next response per port; a write+read request is treated as a write only
    always_comb begin
        port_ready = '0;
        resp_d     = '0;
        valid_d    = '0;
        data_d     = data_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_ready[p] = !port_req[p] || bank_grant[bank_sel[p]][p];
            if (bank_grant[bank_sel[p]][p] && port_read_enable[p] && !port_write_enable[p]) begin
                resp_d[p]  = 1'b1;
                valid_d[p] = bank_rd_vbit[bank_sel[p]];
                data_d[p]  = bank_rd_data[bank_sel[p]];
            end
        end
    end

    // Response register; reset drops any pending response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_q  <= '0;
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            resp_q  <= resp_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign port_resp      = resp_q;
    assign port_valid_out = valid_q;
    assign port_data_out  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bank_array
//  Description : Directed self-checking bench for mem_bank_array with a
//                response scoreboard keyed by port and response cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bank_array;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [15:0] port_addr;
    logic [15:0] port_data_in;
    logic [1:0]  port_read_enable;
    logic [1:0]  port_write_enable;
    logic [1:0]  port_ready;
    logic [1:0]  port_resp;
    logic [1:0]  port_valid_out;
    logic [15:0] port_data_out;

    typedef struct {
        int         port;
        int         cyc;
        logic       valid;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_data [2];
    int         cyc;
    int         checks;
    int         errors;

    mem_bank_array #(
        .DATA_W    (8),
        .ADDR_W    (8),
        .NUM_BANKS (4),
        .NUM_PORTS (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .clear             (clear),
        .port_addr         (port_addr),
        .port_data_in      (port_data_in),
        .port_read_enable  (port_read_enable),
        .port_write_enable (port_write_enable),
        .port_ready        (port_ready),
        .port_resp         (port_resp),
        .port_valid_out    (port_valid_out),
        .port_data_out     (port_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] re, input logic [1:0] we,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic clr);
        port_read_enable  = re;
        port_write_enable = we;
        port_addr         = {a1, a0};
        port_data_in      = {d1, d0};
        clear             = clr;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    endtask

    // Expect a response on port p in the cycle after the coming edge
    task automatic push(input int p, input logic v, input logic [7:0] d);
        exp_t e;
        e.port  = p;
        e.cyc   = cyc + 1;
        e.valid = v;
        e.data  = d;
        sb.push_back(e);
    endtask

    // Response monitor: mid-cycle, compare each port against the scoreboard
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            int hit;
            hit = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (hit < 0 && sb[i].port == p && sb[i].cyc == cyc) hit = i;
            end
            if (hit >= 0) begin
                chk($sformatf("p%0d_resp@%0d", p, cyc), 32'(port_resp[p]), 32'(1));
                chk($sformatf("p%0d_valid@%0d", p, cyc), 32'(port_valid_out[p]), 32'(sb[hit].valid));
                chk($sformatf("p%0d_data@%0d", p, cyc), 32'(port_data_out[p*8 +: 8]), 32'(sb[hit].data));
                last_data[p] = sb[hit].data;
                sb.delete(hit);
            end else begin
                chk($sformatf("p%0d_noresp@%0d", p, cyc), 32'(port_resp[p]), 32'(0));
                chk($sformatf("p%0d_novalid@%0d", p, cyc), 32'(port_valid_out[p]), 32'(0));
                chk($sformatf("p%0d_hold@%0d", p, cyc), 32'(port_data_out[p*8 +: 8]), 32'(last_data[p]));
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        last_data[0] = 8'd0;
        last_data[1] = 8'd0;
        reset        = 1'b1;
        idle();
        #1 reset = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset_resp", 32'(port_resp), 32'(0));
        chk("reset_valid", 32'(port_valid_out), 32'(0));
        chk("reset_data", 32'(port_data_out), 32'(0));
        reset = 1'b1;
        tick();

        // 1: read of never-written addr 0
        drive(2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        #1 chk("t1_ready", 32'(port_ready), 32'(2'b11));
        push(0, 1'b0, 8'd0);
        tick(); idle(); tick();

        // 2: write 9 <- 24, then read it back
        drive(2'b00, 2'b01, 8'd9, 8'd0, 8'd24, 8'd0, 1'b0);
        #1 chk("t2_wr_ready", 32'(port_ready), 32'(2'b11));
        tick();
        drive(2'b01, 2'b00, 8'd9, 8'd0, 8'd0, 8'd0, 1'b0);
        push(0, 1'b1, 8'd24);
        tick();
        // port1 alone on bank 1 returns that arbiter's pointer to 0
        drive(2'b10, 2'b00, 8'd0, 8'd13, 8'd0, 8'd0, 1'b0);
        #1 chk("t2_p1_ready", 32'(port_ready), 32'(2'b11));
        push(1, 1'b0, 8'd0);
        tick(); idle(); tick();

        // 3: bank-1 conflict, twice
        for (int r = 0; r < 2; r++) begin
            drive(2'b11, 2'b00, 8'd9, 8'd13, 8'd0, 8'd0, 1'b0);
            #1 chk($sformatf("t3_conflict_ready_%0d", r), 32'(port_ready), 32'(2'b01));
            push(0, 1'b1, 8'd24);
            tick();
            drive(2'b10, 2'b00, 8'd9, 8'd13, 8'd0, 8'd0, 1'b0);
            #1 chk($sformatf("t3_second_ready_%0d", r), 32'(port_ready), 32'(2'b11));
            push(1, 1'b0, 8'd0);
            tick();
        end
        idle(); tick();

        // 4: write bank 3 and read bank 1 in the same cycle
        drive(2'b10, 2'b01, 8'd255, 8'd9, 8'd145, 8'd0, 1'b0);
        #1 chk("t4_ready", 32'(port_ready), 32'(2'b11));
        push(1, 1'b1, 8'd24);
        tick();
        drive(2'b01, 2'b00, 8'd255, 8'd0, 8'd0, 8'd0, 1'b0);
        push(0, 1'b1, 8'd145);
        tick(); idle(); tick();

        // 5: clear with a concurrent write (addr 4) and read (addr 255, pre-clear valid)
        drive(2'b10, 2'b01, 8'd4, 8'd255, 8'd7, 8'd0, 1'b1);
        #1 chk("t5_ready", 32'(port_ready), 32'(2'b11));
        push(1, 1'b1, 8'd145);
        tick();
        drive(2'b01, 2'b00, 8'd9, 8'd0, 8'd0, 8'd0, 1'b0);
        push(0, 1'b0, 8'd0);
        tick();
        drive(2'b01, 2'b00, 8'd4, 8'd0, 8'd0, 8'd0, 1'b0);
        push(0, 1'b1, 8'd7);
        tick(); idle(); tick();

        // 6: asynchronous reset during a pending response
        drive(2'b01, 2'b00, 8'd4, 8'd0, 8'd0, 8'd0, 1'b0);
        push(0, 1'b1, 8'd7);
        tick();
        idle();
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_resp", 32'(port_resp), 32'(0));
        chk("t6_rst_valid", 32'(port_valid_out), 32'(0));
        chk("t6_rst_data", 32'(port_data_out), 32'(0));
        sb.delete();
        last_data[0] = 8'd0;
        last_data[1] = 8'd0;
        tick();
        reset = 1'b1;
        tick();
        drive(2'b01, 2'b00, 8'd9, 8'd0, 8'd0, 8'd0, 1'b0);
        push(0, 1'b0, 8'd0);
        tick();
        drive(2'b01, 2'b00, 8'd4, 8'd0, 8'd0, 8'd0, 1'b0);
        push(0, 1'b0, 8'd0);
        tick(); idle(); tick(); tick();

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bank_array.md
Name: mem_bank_array

Overview:
Parametrised successor to the single-port bank memory. It holds NUM_BANKS address-interleaved banks with per-word written/valid tracking, shared by NUM_PORTS requesters. Each bank has a round-robin arbiter. A synchronous clear invalidates the whole array. It sits between the DSP core load/store ports and local scratch memory.

Parameters:
DATA_W, 8, data word width
ADDR_W, 8, word address width; total depth 2^ADDR_W
NUM_BANKS, 4, bank count; power of two, at least 2; depth per bank 2^ADDR_W/NUM_BANKS
NUM_PORTS, 2, requester count; at least 1

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
clear  in  1  synchronous invalidate of all word-valid bits
port_addr  in  NUM_PORTS*ADDR_W  per-port word address; port p occupies slice p
port_data_in  in  NUM_PORTS*DATA_W  per-port write data
port_read_enable  in  NUM_PORTS  read request
port_write_enable  in  NUM_PORTS  write request
port_ready  out  NUM_PORTS  combinational grant; request accepted when (re|we)&ready
port_resp  out  NUM_PORTS  read response strobe
port_valid_out  out  NUM_PORTS  addressed word was written since last reset/clear
port_data_out  out  NUM_PORTS*DATA_W  read data

Behaviour:
- Bank select is addr[BSEL_W-1:0], where BSEL_W = log2(NUM_BANKS). Word index is addr[ADDR_W-1:BSEL_W].
- Request: re or we high. If both are high, the request is a write only and produces no response.
- port_ready[p]: high if p has no request, or if p has won its bank's arbiter this cycle. It is purely combinational from requests and arbiter pointers. A losing port must hold its request stable until ready is high.
- Arbiter, one per bank:
  - Pointer ptr in 0..NUM_PORTS-1. The first requesting port at or after ptr (cyclic) wins.
  - On a grant, ptr becomes winner+1 mod NUM_PORTS. With no request, ptr holds.
  - Reset value of ptr is 0.
- Different banks grant independently. Up to min(NUM_PORTS, NUM_BANKS) accesses complete per cycle.
- Write, accepted at edge T: mem[word] <= data and vbit[word] <= 1 at T.
- Read, accepted at edge T: port_resp=1 for exactly the cycle after T. In that cycle:
  - port_valid_out = vbit[word] as sampled at T.
  - port_data_out = mem[word] if vbit=1, else 0.
  - In all other cycles, port_resp=0 and port_valid_out=0. port_data_out holds its last value.
- Read-after-write through one port in consecutive cycles returns the new data. A read and a write to the same bank in the same cycle cannot both be granted.
- clear=1 at edge T: all vbit <= 0.
  - A write accepted at the same T sets its vbit=1 (write wins).
  - A read accepted at T returns pre-clear vbit.
  - Requests are still arbitrated during clear.
- Memory contents are not reset. Only vbit and outputs are reset.
- Reset asserted (reset=0), asynchronously:
  - port_resp=0, port_valid_out=0, port_data_out=0.
  - All vbit=0, all ptr=0.
  - Any pending response is dropped.
- While reset=0, no write takes effect.

Decomposition:
- Package mem_pkg holds:
  - function clog2
  - BSEL_W derivation helper
  - functions for slice extraction from flattened port vectors
- One natural sub-module: mem_bank_slice. It contains one bank's storage, its vbit array, and its round-robin arbiter. Instantiate it NUM_BANKS times in a generate loop. The top level does port-to-bank routing and the response register.

Test Plan:
All scenarios use the defaults: DATA_W=8, ADDR_W=8, NUM_BANKS=4, NUM_PORTS=2.
1. After reset, port0 reads addr 0 -> next cycle port_resp[0]=1, port_valid_out[0]=0, port_data_out[0]=0.
2. Port0 writes addr 9 data 24, then reads 9 on the next cycle -> resp=1, valid_out=1, data_out=24.
3. From reset (ptr=0), port0 reads 9 and port1 reads 13 (both bank 1):
   - First cycle: port_ready=2'b01.
   - Next cycle: port1 granted and port_ready=2'b11.
   - Responses arrive in successive cycles: port0 data 24, then port1 valid_out=0.
   - Repeat the conflict -> port0 wins again (ptr returned to 0 after port1's grant).
4. Same cycle, port0 writes addr 255 data 145 (bank 3) and port1 reads addr 9 (bank 1) -> port_ready=2'b11; next cycle port1 data 24 valid 1. A following read of 255 returns 145.
5. clear=1 in the same cycle as port0 writes addr 4 data 7 -> a later read of 9 gives valid_out=0 and data_out=0; a read of 4 gives valid_out=1 and data_out=7.
6. Assert reset=0 in the cycle after a read is accepted, mid-clock -> port_resp, port_valid_out and port_data_out go to 0 immediately. After release, a read of 9 gives valid_out=0.
